// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: access size encoding, FSM states,
// default ACK timeout and the alignment rule used when a request is accepted.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam int ACK_TIMEOUT_DEF = 16;

  // High when the size is illegal or the byte offset breaks natural alignment.
  function automatic logic access_fault(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: access_fault = 1'b0;
      SZ_HALF: access_fault = lane[0];
      SZ_WORD: access_fault = |lane;
      default: access_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
// Sign extension of byte/half loads exists only when MEM_ACCESS_SIGN_EXT_EN is defined.
module lane_align
  import mem_pkg::*;
(
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        ext_b;
  logic        ext_h;

  assign byte_v = rword_i[{lane_i, 3'b000} +: 8];
  assign half_v = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

`ifdef MEM_ACCESS_SIGN_EXT_EN
  assign ext_b = signed_i & byte_v[7];
  assign ext_h = signed_i & half_v[15];
`else
  // Signed stays on the interface; without the feature every sub-word load zero-extends.
  logic unused_signed;
  assign unused_signed = signed_i;
  assign ext_b = 1'b0;
  assign ext_h = 1'b0;
`endif

  always_comb begin
    load_o = rword_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{ext_b}}, byte_v};
      SZ_HALF: load_o = {{16{ext_h}}, half_v};
      default: load_o = rword_i;
    endcase
  end

  always_comb begin
    merge_o = rword_i;
    case (size_i)
      SZ_BYTE: merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns a one-cycle load/store request into a strobe/ack access on a 32-bit word port,
// with read-modify-write for sub-word stores. Optional macro: MEM_ACCESS_SIGN_EXT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Done,
  output logic        Busy,
  output logic        AddrErr,
  output logic        BusErr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemRd,
  output logic        MemWr,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output state_e      DbgState
);

  // Handshake: a strobe (MemRd or MemWr) is held until MemAck is seen with it
  // high; MemAck with no strobe is ignored, and the strobe drops the cycle after.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic        strobe;
  logic        ack;
  logic        timeout;
  logic [31:0] load_data;
  logic [31:0] merged;

  lane_align u_lane_align (
    .size_i   (size_q),
    .signed_i (signed_q),
    .lane_i   (addr_q[1:0]),
    .rword_i  (MemRData),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merged)
  );

  always_comb begin
    strobe    = rd_q | wr_q;
    ack       = MemAck & strobe;
    timeout   = strobe & ~MemAck & (cnt_q == TO_LAST);
    state_d   = state_q;
    size_d    = size_q;
    signed_d  = signed_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = (strobe & ~MemAck) ? cnt_q + 8'd1 : 8'd0;
    bus_err_d = timeout;

    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          size_d   = size_e'(Size);
          signed_d = Signed;
          addr_d   = Addr;
          wdata_d  = WData;
          if (access_fault(size_e'(Size), Addr[1:0])) state_d = ST_ERR;
          else if (!Wr)                               state_d = ST_RD;
          else if (size_e'(Size) == SZ_WORD)          state_d = ST_WR;
          else                                        state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        if (ack) begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_RMW_RD: begin
        // The merged word replaces the store data and is what RMW_WR writes back.
        if (ack) begin
          wdata_d = merged;
          state_d = ST_RMW_WR;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_WR, ST_RMW_WR: begin
        if (ack || timeout) state_d = ST_DONE;
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    // Strobes rise one cycle after entering a strobe state and fall on leaving it.
    rd_d = ((state_q == ST_RD) || (state_q == ST_RMW_RD)) && (state_d == state_q);
    wr_d = ((state_q == ST_WR) || (state_q == ST_RMW_WR)) && (state_d == state_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign RData    = rdata_q;
  assign Done     = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign Busy     = (state_q != ST_IDLE);
  assign AddrErr  = (state_q == ST_ERR);
  assign BusErr   = bus_err_q;
  assign MemAddr  = {addr_q[31:2], 2'b00};
  assign MemWData = wdata_q;
  assign MemRd    = rd_q;
  assign MemWr    = wr_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized back-to-back traffic
// checked against an arithmetic reference model and a responding word memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int ACK_TO = 16;
  localparam int NEVER  = 255;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req = 1'b0, Wr = 1'b0, Signed = 1'b0, MemAck = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = 32'd0, WData = 32'd0, MemRData = 32'd0;
  logic [31:0] RData, MemAddr, MemWData;
  logic        Done, Busy, AddrErr, BusErr, MemRd, MemWr;
  state_e      dbg_state;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] bus_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rdata = 32'd0;

  mem_access_unit #(.ACK_TIMEOUT(ACK_TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Wr(Wr), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WData(WData), .RData(RData), .Done(Done), .Busy(Busy),
    .AddrErr(AddrErr), .BusErr(BusErr), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRd(MemRd), .MemWr(MemWr), .MemRData(MemRData), .MemAck(MemAck), .DbgState(dbg_state)
  );

  always #5 Clk = ~Clk;

  // Reference: outcome of one access from the size/alignment/endianness rules.
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd, input int dly,
                              output int e_done, output logic [31:0] e_rd, output logic e_ae,
                              output logic e_be, output int e_rdc, output int e_wrc,
                              output logic [31:0] e_wdata);
    int sh, idx, ph;
    logic [31:0] w, v, mask;
    logic sx;
    sh = 8 * int'(addr[1:0]);
    idx = int'(addr[9:2]);
    w = ref_mem[idx];
    ph = (dly >= ACK_TO) ? ACK_TO : dly + 1;
    e_ae = 1'b0; e_be = (dly >= ACK_TO); e_rdc = 0; e_wrc = 0; e_wdata = 32'd0;
`ifdef MEM_ACCESS_SIGN_EXT_EN
    sx = sgn;
`else
    sx = 1'b0 & sgn;
`endif
    if (sz == 2'b11 || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) begin
      e_ae = 1'b1; e_be = 1'b0; e_done = 1;
    end else if (!wr) begin
      e_rdc = ph; e_done = 2 + ph;
      if (!e_be) begin
        v = w >> sh;
        if (sz == 2'b00) begin
          v = v & 32'hFF;
          if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
          v = v & 32'hFFFF;
          if (sx && v[15]) v = v | 32'hFFFF_0000;
        end
        ref_rdata = v;
      end
    end else if (sz == 2'b10) begin
      e_wrc = ph; e_done = 2 + ph; e_wdata = wd;
      if (!e_be) ref_mem[idx] = wd;
    end else begin
      e_rdc = ph;
      if (e_be) e_done = 2 + ph;
      else begin
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        e_wdata = (w & ~mask) | ((wd << sh) & mask);
        e_wrc = ph; e_done = 3 + 2 * ph;
        ref_mem[idx] = e_wdata;
      end
    end
    e_rd = ref_rdata;
  endtask

  // Driver + memory responder. Call at a negedge with the DUT idle; returns at the
  // negedge of the idle cycle after Done, so the next call issues back to back.
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd, input int dly,
                            output int done_cyc, output logic [31:0] rd, output logic ae,
                            output logic be, output int rd_cyc, output int wr_cyc,
                            output logic both, output logic [31:0] last_wd,
                            output logic addr_ok, output logic busy_ok);
    int run;
    logic [31:0] exp_maddr;
    exp_maddr = {addr[31:2], 2'b00};
    done_cyc = -1; rd = 32'd0; ae = 1'b0; be = 1'b0; rd_cyc = 0; wr_cyc = 0;
    both = 1'b0; last_wd = 32'd0; addr_ok = 1'b1; busy_ok = 1'b1; run = 0;
    Req = 1'b1; Wr = wr; Size = sz; Signed = sgn; Addr = addr; WData = wd; MemAck = 1'b0;
    @(posedge Clk);
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge Clk);
      Req = 1'b0; Wr = 1'($urandom); Size = 2'($urandom); Signed = 1'($urandom);
      Addr = $urandom; WData = $urandom; MemAck = 1'b0; MemRData = $urandom;
      if (MemRd && MemWr) both = 1'b1;
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (MemRd || MemWr) begin
        if (MemAddr !== exp_maddr) addr_ok = 1'b0;
        if (MemRd) rd_cyc++; else wr_cyc++;
        run++;
        if (dly < NEVER && run == dly + 1) begin
          MemAck = 1'b1;
          if (MemRd) MemRData = bus_mem[MemAddr[9:2]];
          else begin
            bus_mem[MemAddr[9:2]] = MemWData;
            last_wd = MemWData;
          end
        end
      end else begin
        run = 0;
        MemAck = 1'($urandom_range(0, 1));
      end
      if (Done === 1'b1) begin
        done_cyc = cyc; rd = RData; ae = AddrErr; be = BusErr;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    MemAck = 1'b0;
    if (Busy !== 1'b0 || Done !== 1'b0 || MemRd !== 1'b0 || MemWr !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #13;
    chk_cnt++; if ({RData, Done, Busy, AddrErr, BusErr, MemAddr, MemWData, MemRd, MemWr} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {RData, Done, Busy, AddrErr, BusErr, MemAddr, MemWData, MemRd, MemWr});
    else pass_cnt++;
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);
    ref_rdata = 32'd0;
  endtask

  task automatic test_lbu();
    int dc, rc, wc; logic [31:0] rd, lw; logic ae, be, both, aok, bok;
    bus_mem[64] = 32'hA1B2_C3D4; ref_mem[64] = 32'hA1B2_C3D4;
    run_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 0, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    ref_rdata = 32'h0000_00A1;
    chk_cnt++; if (dc !== 3) $display("FAIL lbu_latency: got %0d want 3", dc); else pass_cnt++;
    chk_cnt++; if (rd !== 32'h0000_00A1) $display("FAIL lbu_rdata: got %h want 000000a1", rd); else pass_cnt++;
    chk_cnt++; if (aok !== 1'b1) $display("FAIL lbu_memaddr: got bad want 00000100"); else pass_cnt++;
    chk_cnt++; if ({ae, be, rc, wc, bok} !== {2'b00, 32'd1, 32'd0, 1'b1})
      $display("FAIL lbu_flags: got ae=%b be=%b rd=%0d wr=%0d busy=%b want 0 0 1 0 1", ae, be, rc, wc, bok);
    else pass_cnt++;
  endtask

  task automatic test_sh_rmw();
    int dc, rc, wc; logic [31:0] rd, lw; logic ae, be, both, aok, bok;
    bus_mem[128] = 32'h1122_3344; ref_mem[128] = 32'h1122_3344;
    run_access(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 0, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    ref_mem[128] = 32'hBEEF_3344;
    chk_cnt++; if (dc !== 5) $display("FAIL sh_latency: got %0d want 5", dc); else pass_cnt++;
    chk_cnt++; if (lw !== 32'hBEEF_3344) $display("FAIL sh_wdata: got %h want beef3344", lw); else pass_cnt++;
    chk_cnt++; if (both !== 1'b0) $display("FAIL sh_strobe_overlap: got 1 want 0"); else pass_cnt++;
    chk_cnt++; if (rc !== 1 || wc !== 1) $display("FAIL sh_strobes: got rd=%0d wr=%0d want 1 1", rc, wc); else pass_cnt++;
    chk_cnt++; if (bus_mem[128] !== 32'hBEEF_3344) $display("FAIL sh_memory: got %h want beef3344", bus_mem[128]); else pass_cnt++;
    chk_cnt++; if (rd !== ref_rdata) $display("FAIL sh_rdata_held: got %h want %h", rd, ref_rdata); else pass_cnt++;
  endtask

  task automatic test_addr_err();
    int dc, rc, wc; logic [31:0] rd, lw; logic ae, be, both, aok, bok;
    logic [31:0] err_addr [3];
    logic [1:0]  err_size [3];
    logic        err_wr   [3];
    err_addr = '{32'h0000_0006, 32'h0000_0010, 32'h0000_0201};
    err_size = '{2'b10, 2'b11, 2'b01};
    err_wr   = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_access(err_wr[i], err_size[i], 1'b0, err_addr[i], $urandom, 0, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
      chk_cnt++; if (dc !== 1) $display("FAIL err%0d_latency: got %0d want 1", i, dc); else pass_cnt++;
      chk_cnt++; if ({ae, be} !== 2'b10) $display("FAIL err%0d_flags: got ae=%b be=%b want 1 0", i, ae, be); else pass_cnt++;
      chk_cnt++; if (rc + wc !== 0) $display("FAIL err%0d_no_access: got %0d strobe cycles want 0", i, rc + wc); else pass_cnt++;
      chk_cnt++; if (rd !== ref_rdata || bok !== 1'b1)
        $display("FAIL err%0d_held: got rdata=%h busy=%b want %h 1", i, rd, bok, ref_rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int dc, rc, wc; logic [31:0] rd, lw; logic ae, be, both, aok, bok;
    bus_mem[192] = 32'h5A5A_0F0F; ref_mem[192] = 32'h5A5A_0F0F;
    run_access(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, NEVER, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    chk_cnt++; if (wc !== ACK_TO || rc !== 0) $display("FAIL to_strobe_len: got wr=%0d rd=%0d want %0d 0", wc, rc, ACK_TO); else pass_cnt++;
    chk_cnt++; if (dc !== ACK_TO + 2) $display("FAIL to_latency: got %0d want %0d", dc, ACK_TO + 2); else pass_cnt++;
    chk_cnt++; if ({ae, be} !== 2'b01) $display("FAIL to_flags: got ae=%b be=%b want 0 1", ae, be); else pass_cnt++;
    chk_cnt++; if (rd !== ref_rdata || bok !== 1'b1) $display("FAIL to_idle: got rdata=%h busy=%b want %h 1", rd, bok, ref_rdata); else pass_cnt++;
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 1, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    ref_rdata = 32'h5A5A_0F0F;
    chk_cnt++; if (dc !== 4 || rd !== 32'h5A5A_0F0F || be !== 1'b0)
      $display("FAIL to_next_lw: got done=%0d rdata=%h be=%b want 4 5a5a0f0f 0", dc, rd, be);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dc, rc, wc, bad; logic [31:0] rd, lw; logic ae, be, both, aok, bok;
    Req = 1'b1; Wr = 1'b1; Size = 2'b01; Signed = 1'b0; Addr = 32'h0000_0042; WData = 32'h0000_1234;
    @(posedge Clk); @(negedge Clk); Req = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk_cnt++; if (MemRd !== 1'b1 || MemWr !== 1'b0) $display("FAIL rst_mid_rmw_rd: got rd=%b wr=%b want 1 0", MemRd, MemWr); else pass_cnt++;
    #2 Reset_n = 1'b0;
    #1;
    chk_cnt++; if ({RData, Done, Busy, AddrErr, BusErr, MemAddr, MemWData, MemRd, MemWr} !== '0)
      $display("FAIL rst_mid_outputs: got %h want 0", {RData, Done, Busy, AddrErr, BusErr, MemAddr, MemWData, MemRd, MemWr});
    else pass_cnt++;
    bad = 0;
    repeat (3) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0 || MemRd !== 1'b0) bad++;
    end
    chk_cnt++; if (bad !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles want 0", bad); else pass_cnt++;
    Reset_n = 1'b1;
    ref_rdata = 32'd0;
    run_access(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 0, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    ref_rdata = ref_mem[192];
    chk_cnt++; if (dc !== 3 || rd !== ref_mem[192]) $display("FAIL rst_mid_after: got done=%0d rdata=%h want 3 %h", dc, rd, ref_mem[192]); else pass_cnt++;
    chk_cnt++; if (bus_mem[16] !== ref_mem[16]) $display("FAIL rst_mid_no_write: got %h want %h", bus_mem[16], ref_mem[16]); else pass_cnt++;
  endtask

  task automatic test_sign_ext();
    int dc, rc, wc; logic [31:0] rd, lw, exp_h, exp_b; logic ae, be, both, aok, bok;
`ifdef MEM_ACCESS_SIGN_EXT_EN
    exp_h = 32'hFFFF_8001; exp_b = 32'hFFFF_FF80;
`else
    exp_h = 32'h0000_8001; exp_b = 32'h0000_0080;
`endif
    bus_mem[0] = 32'h0000_8001; ref_mem[0] = 32'h0000_8001;
    run_access(1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'd0, 0, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    chk_cnt++; if (rd !== exp_h || dc !== 3) $display("FAIL lh_signed: got %h done=%0d want %h 3", rd, dc, exp_h); else pass_cnt++;
    run_access(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'd0, 2, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    chk_cnt++; if (rd !== exp_b || dc !== 5) $display("FAIL lb_signed: got %h done=%0d want %h 5", rd, dc, exp_b); else pass_cnt++;
    run_access(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'd0, 0, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
    ref_rdata = 32'h0000_8001;
    chk_cnt++; if (rd !== 32'h0000_8001) $display("FAIL lhu_zero: got %h want 00008001", rd); else pass_cnt++;
  endtask

  task automatic test_random_back_to_back();
    int dc, rc, wc, dly, e_done, e_rdc, e_wrc, bad;
    logic [31:0] rd, lw, addr, wd, e_rd, e_wd;
    logic ae, be, both, aok, bok, wr, sgn, e_ae, e_be;
    logic [1:0] sz;
    for (int n = 0; n < 120; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sgn = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) addr[1:0] = 2'b00;
        if (sz == 2'b01) addr[0] = 1'b0;
      end
      wd  = $urandom;
      dly = ($urandom_range(0, 24) == 0) ? NEVER : $urandom_range(0, 3);
      model_access(wr, sz, sgn, addr, wd, dly, e_done, e_rd, e_ae, e_be, e_rdc, e_wrc, e_wd);
      run_access(wr, sz, sgn, addr, wd, dly, dc, rd, ae, be, rc, wc, both, lw, aok, bok);
      chk_cnt++; if (dc !== e_done) $display("FAIL rnd%0d_latency: got %0d want %0d", n, dc, e_done); else pass_cnt++;
      chk_cnt++; if (rd !== e_rd) $display("FAIL rnd%0d_rdata: got %h want %h", n, rd, e_rd); else pass_cnt++;
      chk_cnt++; if ({ae, be} !== {e_ae, e_be}) $display("FAIL rnd%0d_flags: got %b%b want %b%b", n, ae, be, e_ae, e_be); else pass_cnt++;
      chk_cnt++; if (rc !== e_rdc || wc !== e_wrc) $display("FAIL rnd%0d_strobes: got %0d/%0d want %0d/%0d", n, rc, wc, e_rdc, e_wrc); else pass_cnt++;
      chk_cnt++; if ({both, aok, bok} !== 3'b011) $display("FAIL rnd%0d_protocol: got both=%b addr=%b busy=%b want 0 1 1", n, both, aok, bok); else pass_cnt++;
      if (e_wrc > 0 && e_wrc < ACK_TO) begin
        chk_cnt++; if (lw !== e_wd) $display("FAIL rnd%0d_wdata: got %h want %h", n, lw, e_wd); else pass_cnt++;
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (bus_mem[i] !== ref_mem[i]) bad++;
    chk_cnt++; if (bad !== 0) $display("FAIL rnd_memory_image: got %0d differing words want 0", bad); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    test_reset();
    test_lbu();
    test_sh_rmw();
    test_addr_err();
    test_timeout();
    test_reset_mid();
    test_sign_ext();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before 2ms");
    $fatal(1);
  end

endmodule
